iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Multi-cycle RV32M divide/remainder unit in the frisc execute stage.
- Consumes operands from the register-read stage.
- Its result is one data input of the one-hot ALU result select mux that feeds writeback.
- Implements DIV, DIVU, REM and REMU with RISC-V architectural corner-case results, using a one-bit-per-cycle restoring algorithm.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept a new operation.
- op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU (matches funct3[1:0]).
- dividend  input  WIDTH  rs1 value.
- divisor  input  WIDTH  rs2 value.
- kill  input  1  abort any in-flight operation (pipeline flush).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, iteration counter=0.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) && !kill.
- Accept happens on in_valid && in_ready.

State transitions:
- IDLE, on accept: latch op, latch operand magnitudes, latch the quotient and remainder sign flags.
  - Magnitudes: absolute values when op[0]==0 (signed), raw values otherwise.
  - Quotient sign = sign(dividend) XOR sign(divisor), signed ops only.
  - Remainder sign = sign(dividend), signed ops only.
  - Clear the partial remainder and the counter; go to BUSY.
- BUSY, each cycle: one restoring step.
  - Shift {partial remainder, quotient} left by 1, bringing in the next dividend MSB.
  - If partial remainder >= divisor magnitude: subtract it and set the quotient LSB to 1.
  - Increment the counter.
  - After the WIDTH-th step, go to DONE.
- Entry to DONE: register result.
  - Select quotient when op[1]==0, remainder otherwise.
  - Apply two's-complement negation per the latched sign flag.
- DONE: out_valid=1. Result is held stable until out_ready; on out_ready go to IDLE (out_valid=0 next cycle).
- Latency: accept at edge N gives out_valid first high in cycle N+WIDTH+1.
- No new accept while in DONE; back-to-back throughput is one op per WIDTH+2 cycles minimum.

Arithmetic rules:
- Internal partial remainder is WIDTH+1 bits so the compare/subtract cannot overflow.
- abs(most negative) is taken as an unsigned WIDTH-bit value (2^(WIDTH-1)).
- Divide by zero:
  - Quotient = all ones (-1 signed, 2^WIDTH-1 unsigned).
  - Remainder = dividend unchanged, signed or unsigned.
  - The restoring algorithm yields these naturally for unsigned ops. For signed ops the sign fix-up must be suppressed when divisor==0.
- Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.

Kill and reset:
- kill in any state: next state IDLE, out_valid=0; the in-flight result is discarded.
- kill takes priority over accept and over out_ready.
- reset mid-operation: identical to the reset values above; no output glitch after the edge.

Simultaneous events:
- In DONE with out_ready=1 and in_valid=1: no accept that cycle (in_ready=0). The accept happens the following cycle.

Optional Feature:
- Macro: FRISC_DIV_EARLY_OUT_EN.
- Defined:
  - An accept whose divisor==0, or a signed-overflow accept, bypasses BUSY and goes IDLE to DONE with the architectural result.
  - out_valid is high in cycle N+1.
  - All other ops keep WIDTH+1 latency.
- Undefined:
  - Every op takes the full WIDTH+1 cycles.
  - Result values are bit-identical to the defined case.

Test Plan:
- DIVU 100/7, out_ready=1: result=14 with out_valid at accept+33 (WIDTH=32); REMU 100/7 gives 2.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); REM 7/-2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0. Check latency 1 cycle with FRISC_DIV_EARLY_OUT_EN and 33 without.
- DIVU 100/7 with out_ready held 0 for 5 cycles after out_valid: result stays 14 and in_ready stays 0 throughout. out_ready=1 gives out_valid=0 and in_ready=1 next cycle.
- kill asserted at iteration 10 of DIVU 100/7: next cycle state IDLE, out_valid never asserts. A following DIVU 9/3 gives 3 with full latency.
- reset asserted at iteration 5, in DONE, and together with in_valid: next cycle out_valid=0, in_ready=1, result=0.

Source files
------------

// File: rtl/iterative_divider_if.sv
// Handshake bundle for the RV32M iterative divider: operand request,
// pipeline kill, and result response.
interface iterative_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op, dividend, divisor, kill, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, kill, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU unit, restoring one bit per cycle.
// FRISC_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip BUSY.
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    iterative_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             accept;
    logic             last_step;
    logic             early;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   partial;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] sel;
    logic             sel_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) state_d = early ? DONE : BUSY;
                BUSY: if (last_step) state_d = DONE;
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !bus.kill;
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        accept        = bus.in_valid && bus.in_ready;

        is_signed = !bus.op[0];
        a_neg     = is_signed && bus.dividend[WIDTH-1];
        b_neg     = is_signed && bus.divisor[WIDTH-1];
        a_mag     = a_neg ? -bus.dividend : bus.dividend;
        b_mag     = b_neg ? -bus.divisor : bus.divisor;
        div_zero  = (bus.divisor == '0);

        // The MSB of partial only feeds the compare; after a subtract the
        // difference always fits in WIDTH bits.
        partial   = {rem_q, quo_q[WIDTH-1]};
        ge        = (partial >= {1'b0, div_q});
        rem_step  = ge ? (partial[WIDTH-1:0] - div_q) : partial[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], ge};
        last_step = (cnt_q == CW'(WIDTH - 1));
        sel       = op_q[1] ? rem_step : quo_step;
        sel_neg   = op_q[1] ? rneg_q : qneg_q;

        op_d     = op_q;
        div_d    = div_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        early    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = bus.op;
                    div_d  = b_mag;
                    quo_d  = a_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    // Dividing by zero must leave the all-ones quotient as is.
                    qneg_d = (a_neg ^ b_neg) && !div_zero;
                    rneg_d = a_neg;
`ifdef FRISC_DIV_EARLY_OUT_EN
                    early = div_zero ||
                            (is_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                             (bus.divisor == '1));
                    if (early) begin
                        if (bus.op[1]) result_d = div_zero ? bus.dividend : '0;
                        else           result_d = div_zero ? '1 : bus.dividend;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) result_d = sel_neg ? -sel : sel;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: random traffic against an
// arithmetic reference model, plus directed corner cases with literal results.
module tb_iterative_divider;
    localparam int W = 32;
    localparam int FULL_LAT = W + 1;
`ifdef FRISC_DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = W + 1;
`endif

    logic clk;
    logic reset;

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
            return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: one outstanding op, visible from a known edge until handed off.
    int unsigned    cyc = 0;
    int unsigned    due = 0;
    bit             pending = 0;
    bit             started = 0;
    bit             res_known = 0;
    logic [W-1:0]   exp_res = '0;

    always @(posedge clk) begin
        bit vnow;
        vnow = pending && (cyc >= due);
        cyc++;
        started = 1;
        if (reset) begin
            pending   = 0;
            exp_res   = '0;
            res_known = 1;
        end else if (bus.kill) begin
            pending = 0;
        end else if (pending) begin
            if (vnow && bus.out_ready) pending = 0;
        end else if (bus.in_valid) begin
            pending   = 1;
            exp_res   = ref_result(bus.op, bus.dividend, bus.divisor);
            res_known = 0;
            due       = cyc + (is_special(bus.op, bus.dividend, bus.divisor) ?
                               EARLY_LAT : FULL_LAT) - 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = pending && (cyc >= due);
            check("out_valid", {31'b0, bus.out_valid}, {31'b0, ev});
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, !pending && !bus.kill});
            if (ev || (!pending && res_known)) check("result", bus.result, exp_res);
            if (ev) res_known = 1;
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        check("start_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 200);
        if (!bus.out_valid) check("valid_timeout", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic directed(input string name, input logic [1:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input int hold);
        int lat;
        logic [W-1:0] first;
        bus.out_ready = 1'b0;
        start_op(o, a, b);
        wait_valid(lat);
        first = bus.result;
        check({name, "_res"}, first, exp);
        check({name, "_lat"}, lat, is_special(o, a, b) ? EARLY_LAT : FULL_LAT);
        repeat (hold) begin
            @(negedge clk);
            check({name, "_hold"}, bus.result, first);
            check({name, "_hold_ready"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({name, "_drop_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({name, "_back_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'(-$urandom_range(1, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        bit seen;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rst_result", bus.result, 32'h0);
        check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        directed("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 0);
        directed("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 0);
        directed("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        directed("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        directed("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
        directed("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        directed("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 0);
        directed("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
        directed("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        directed("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        directed("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
        directed("divu_hold", 2'b01, 32'd100, 32'd7, 32'd14, 5);

        // Kill during iteration 10, then a clean op with full latency.
        start_op(2'b01, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        check("kill_idle", {31'b0, bus.in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("kill_no_valid", {31'b0, seen}, 32'd0);
        directed("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 0);

        // DONE with out_ready and in_valid together: accept waits a cycle.
        start_op(2'b01, 32'd100, 32'd7);
        wait_valid(lat);
        bus.in_valid  = 1'b1;
        bus.op        = 2'b01;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        bus.out_ready = 1'b1;
        #1;
        check("done_no_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("next_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_res", bus.result, 32'd3);
        check("b2b_lat", lat, FULL_LAT);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset at iteration 5.
        start_op(2'b01, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_busy_result", bus.result, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset while in DONE.
        start_op(2'b01, 32'd100, 32'd7);
        wait_valid(lat);
        reset = 1'b1;
        @(negedge clk);
        check("rst_done_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_done_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_done_result", bus.result, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset together with in_valid: no accept.
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_inv_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_inv_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_inv_result", bus.result, 32'h0);
        repeat (40) @(posedge clk);

        // Random traffic, checked every cycle by the model compare process.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.op        = 2'($urandom_range(0, 3));
            bus.dividend  = rnd_operand();
            bus.divisor   = rnd_operand();
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.kill      = $urandom_range(0, 79) == 0;
            reset         = $urandom_range(0, 499) == 0;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        pulse_reset();
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
